on_chip_fsm_status_in: RTL and testbench

Avalon-MM slave input port: the read-side counterpart to the team's write-only output PIOs. It samples a 32-bit `in_port` from fabric status logic (FSM flags, ball-detect status). The Nios II reads the sampled value, a per-bit edge-capture register and an interrupt mask, and `irq` is asserted on unmasked captured edges. The block sits on the on-chip FSM Avalon interconnect beside the output PIOs.

---
 rtl/on_chip_fsm_status_in.sv | 106 ++++++++++
 tb/tb_on_chip_fsm_status_in.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/on_chip_fsm_status_in.sv
// on_chip_fsm_status_in: Avalon-MM status input port with per-bit edge capture and masked irq.
// Define ON_CHIP_FSM_IN_SYNC_EN to add a metastability stage in front of sync for asynchronous in_port.
module on_chip_fsm_status_in #(
    parameter int          EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [31:0] in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_RSVD = 2'd3
    } reg_addr_e;

    logic [31:0] sync;
    logic [31:0] prev;
    logic [31:0] mask;
    logic [31:0] ec;
    logic [31:0] edge_bits;
    logic [31:0] clr;
    logic        wr_en;

`ifdef ON_CHIP_FSM_IN_SYNC_EN
    logic [31:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= in_port;
            sync <= meta;
            prev <= sync;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync <= in_port;
            prev <= sync;
        end
    end
`endif

    // prev and sync both reset to 0, so a bit held high through reset reports exactly one rising edge.
    always_comb begin
        edge_bits = sync ^ prev;
        case (EDGE_TYPE)
            0:       edge_bits = sync & ~prev;
            1:       edge_bits = ~sync & prev;
            default: edge_bits = sync ^ prev;
        endcase
    end

    assign wr_en = chipselect && !write_n;
    assign clr   = (wr_en && reg_addr_e'(address) == ADDR_EDGE) ? writedata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= RESET_MASK;
        end else if (wr_en && reg_addr_e'(address) == ADDR_MASK) begin
            mask <= writedata;
        end
    end

    // Set is ORed in after the clear so a same-cycle edge keeps the bit at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ec <= '0;
        end else begin
            ec <= (ec & ~clr) | edge_bits;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (reg_addr_e'(address))
                ADDR_DATA: readdata <= sync;
                ADDR_MASK: readdata <= mask;
                ADDR_EDGE: readdata <= ec;
                ADDR_RSVD: readdata <= '0;
            endcase
        end
    end

    // NOTE: irq decodes registers only, so it falls with the asynchronous reset and has no bus path.
    assign irq = |(ec & mask);

endmodule

// File: tb/tb_on_chip_fsm_status_in.sv
// Testbench for on_chip_fsm_status_in: two instances (rising-edge and any-edge) on a shared bus,
// compared with a history-based reference model plus directed constant expectations.
module tb_on_chip_fsm_status_in;

`ifdef ON_CHIP_FSM_IN_SYNC_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif
    localparam int LAT = 2 + D;
    localparam logic [31:0] RM2 = 32'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    int errors = 0;
    int checks = 0;

    on_chip_fsm_status_in #(.EDGE_TYPE(0), .RESET_MASK(32'h0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    on_chip_fsm_status_in #(.EDGE_TYPE(2), .RESET_MASK(RM2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in_port sampled at every edge since reset; register values follow the map rules.
    logic [31:0] hist[$];
    logic [31:0] m_mask[2];
    logic [31:0] m_ec[2];
    logic [31:0] m_rd[2];
    int          etype[2] = '{0, 2};

    function automatic logic [31:0] h(int i);
        return (i < 0) ? 32'h0 : hist[i];
    endfunction

    function automatic logic [31:0] edge_of(int t, logic [31:0] now_v, logic [31:0] old_v);
        if (t == 0) return now_v & ~old_v;
        if (t == 1) return ~now_v & old_v;
        return now_v ^ old_v;
    endfunction

    function automatic logic m_irq(int i);
        return |(m_ec[i] & m_mask[i]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            m_mask <= '{32'h0, RM2};
            m_ec   <= '{32'h0, 32'h0};
            m_rd   <= '{32'h0, 32'h0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (address)
                    2'd0:    m_rd[i] <= h(hist.size() - 1 - D);
                    2'd1:    m_rd[i] <= m_mask[i];
                    2'd2:    m_rd[i] <= m_ec[i];
                    default: m_rd[i] <= 32'h0;
                endcase
                m_ec[i] <= (m_ec[i] & ~((chipselect && !write_n && address == 2'd2) ? writedata : 32'h0))
                           | edge_of(etype[i], h(hist.size() - 1 - D), h(hist.size() - 2 - D));
                if (chipselect && !write_n && address == 2'd1) m_mask[i] <= writedata;
            end
            hist.push_back(in_port);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) tick();
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h want 0", rd0); end
        checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b%b want 00", irq0, irq2); end
        reset_n = 1'b1;
        tick();
        bus_read(2'd1);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_mask0: got %h want 0", rd0); end
        checks++; if (rd2 !== RM2) begin errors++; $display("FAIL reset_mask2: got %h want %h", rd2, RM2); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h0 || rd2 !== 32'h0) begin errors++; $display("FAIL reset_edge: got %h %h want 0 0", rd0, rd2); end
    endtask

    task automatic test_rise();
        bus_write(2'd1, 32'h1);
        in_port = 32'h1;
        repeat (LAT - 1) tick();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rise_early_irq: got %b want 0", irq0); end
        tick();
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL rise_irq0: got %b want 1", irq0); end
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL rise_irq2: got %b want 1", irq2); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL rise_edge: got %h want 1", rd0); end
        in_port = 32'h0;
        repeat (LAT + 1) tick();
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL fall_no_capture: got %h want 1", rd0); end
        bus_read(2'd0);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rise_data: got %h want 0", rd0); end
    endtask

    task automatic test_clear();
        bus_write(2'd2, 32'h1);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL clear_irq: got %b want 0", irq0); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL clear_edge: got %h want 0", rd0); end
        in_port = 32'h1;
        repeat (1 + D) tick();
        bus_write(2'd2, 32'h1);
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq0); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL set_wins_edge: got %h want 1", rd0); end
        in_port = 32'h0;
        repeat (LAT + 1) tick();
        bus_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_mask();
        bus_write(2'd1, 32'h0);
        in_port = 32'h00FF_0000;
        repeat (LAT + 1) tick();
        in_port = 32'h0;
        repeat (LAT + 1) tick();
        checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b%b want 00", irq0, irq2); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h00FF_0000) begin errors++; $display("FAIL masked_edge0: got %h want 00ff0000", rd0); end
        checks++; if (rd2 !== 32'h00FF_0000) begin errors++; $display("FAIL masked_edge2: got %h want 00ff0000", rd2); end
        bus_write(2'd1, 32'h0001_0000);
        checks++; if (irq0 !== 1'b1 || irq2 !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b%b want 11", irq0, irq2); end
        bus_read(2'd1);
        checks++; if (rd0 !== 32'h0001_0000) begin errors++; $display("FAIL mask_readback: got %h want 00010000", rd0); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL clear_all_irq: got %b%b want 00", irq0, irq2); end
    endtask

    task automatic test_any_edge();
        logic [31:0] seq[3];
        seq = '{32'h8000_0000, 32'h0, 32'h8000_0000};
        bus_write(2'd1, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            in_port = seq[i];
            repeat (LAT) tick();
            checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq[%0d]: got %b want 1", i, irq2); end
            bus_read(2'd2);
            checks++; if (rd2 !== 32'h8000_0000) begin errors++; $display("FAIL any_edge[%0d]: got %h want 80000000", i, rd2); end
            bus_write(2'd2, 32'h8000_0000);
            checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_clear[%0d]: got %b want 0", i, irq2); end
        end
        in_port = 32'h0;
        repeat (LAT + 1) tick();
        bus_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ $urandom();
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom();
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (((i == 0) ? rd0 : rd2) !== m_rd[i]) begin
                    errors++; $display("FAIL rand_rd%0d cyc %0d: got %h want %h", i * 2, n, (i == 0) ? rd0 : rd2, m_rd[i]);
                end
                checks++;
                if (((i == 0) ? irq0 : irq2) !== m_irq(i)) begin
                    errors++; $display("FAIL rand_irq%0d cyc %0d: got %b want %b", i * 2, n, (i == 0) ? irq0 : irq2, m_irq(i));
                end
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus_write(2'd1, 32'h1);
        in_port = 32'h0;
        repeat (LAT + 1) tick();
        in_port = 32'h1;
        repeat (LAT) tick();
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq0); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b%b want 00", irq0, irq2); end
        in_port = 32'h0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        bus_read(2'd1);
        checks++; if (rd0 !== 32'h0 || rd2 !== RM2) begin errors++; $display("FAIL post_reset_mask: got %h %h want 0 %h", rd0, rd2, RM2); end
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h0 || rd2 !== 32'h0) begin errors++; $display("FAIL post_reset_edge: got %h %h want 0 0", rd0, rd2); end
        bus_read(2'd0);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h want 0", rd0); end
        checks++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b%b want 00", irq0, irq2); end
    endtask

    task automatic test_reset_held_high();
        reset_n = 1'b0;
        in_port = 32'h4;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (LAT) tick();
        bus_read(2'd2);
        checks++; if (rd0 !== 32'h4 || rd0 !== m_rd[0]) begin errors++; $display("FAIL held_high_edge: got %h want 4", rd0); end
        in_port = 32'h0;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        test_reset();
        test_rise();
        test_clear();
        test_mask();
        test_any_edge();
        test_random();
        test_reset_mid();
        test_reset_held_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
